// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: instruction fetch stage feeding decode.
// Owns the PC and drives a word address into a synchronous instruction memory
// that has 1-cycle read latency. Fetched words are returned through a 2-entry
// buffer (head = presented word, tail = next word), so a decode stall never
// drops a word that is still in flight. The stage supports branch redirect
// with flush, and it stops fetching once a HALT word has been captured.
// Ports:
//   Clk, Reset           rising-edge clock, synchronous active-high reset
//   MemAddr / MemInst    word address out / read data in (one cycle later)
//   RedirectValid/PC     redirect request and target word address
//   InstValid/InstReady  handshake to decode; InstOut/InstPC carry the head word
//   Halted               set once decode has accepted a HALT word
module fetch_unit #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [7:0]  HALT_OPCODE = 8'h0F
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemInst,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPC,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] InstOut,
    output logic [31:0] InstPC,
    output logic        Halted
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [AW-1:0] pc;
    logic [AW-1:0] inflight_pc;
    logic          inflight;
    logic          stop;
    logic          halted_q;

    // Two-entry buffer; the head registers double as the output registers.
    logic [31:0]   head_inst;
    logic [AW-1:0] head_pc;
    logic [31:0]   tail_inst;
    logic [AW-1:0] tail_pc;
    logic [1:0]    count;

    logic          pop;
    logic          push;
    logic          halt_capture;
    logic          issue;
    logic [1:0]    count_after_pop;
    logic [2:0]    occupancy;

    // The redirect target uses only the low address bits (wraps modulo depth).
    logic          unused_redirect_hi;
    assign unused_redirect_hi = ^RedirectPC[31:AW];

    // Handshake and issue decisions for this edge.
    always_comb begin
        pop             = (count != 2'd0) && InstReady;
        push            = inflight && !RedirectValid;
        halt_capture    = inflight && (MemInst[31:24] == HALT_OPCODE);
        count_after_pop = count - 2'(pop);
        // An issue is allowed only if the buffer will have room when the word lands.
        occupancy       = 3'(count) + 3'(inflight) - 3'(pop);
        issue           = !stop && !RedirectValid && !halt_capture && (occupancy < 3'd2);
    end

    // PC, in-flight tracking, buffer and halt state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc          <= AW'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head_inst   <= '0;
            head_pc     <= '0;
            tail_inst   <= '0;
            tail_pc     <= '0;
            count       <= 2'd0;
            stop        <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            if (RedirectValid) begin
                // A same-edge pop is still accepted; everything else is flushed.
                count    <= 2'd0;
                pc       <= RedirectPC[AW-1:0];
                stop     <= 1'b0;
                halted_q <= 1'b0;
            end else begin
                if (pop && (head_inst[31:24] == HALT_OPCODE)) begin
                    halted_q <= 1'b1;
                end
                if (pop && (count == 2'd2)) begin
                    head_inst <= tail_inst;
                    head_pc   <= tail_pc;
                end
                if (push) begin
                    if (count_after_pop == 2'd0) begin
                        head_inst <= MemInst;
                        head_pc   <= inflight_pc;
                    end else begin
                        tail_inst <= MemInst;
                        tail_pc   <= inflight_pc;
                    end
                end
                count <= count_after_pop + 2'(push);
                if (halt_capture) begin
                    stop <= 1'b1;
                end
                if (issue) begin
                    inflight_pc <= pc;
                    pc          <= pc + 1'b1;
                end
            end
            inflight <= issue;
        end
    end

    assign MemAddr   = 32'(pc);
    assign InstValid = (count != 2'd0);
    assign InstOut   = head_inst;
    assign InstPC    = 32'(head_pc);
    assign Halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed test of fetch_unit against a queue-based reference
// model, with an instruction memory modelled as a 1-cycle synchronous read.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        halted;

    logic [31:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .MEM_DEPTH  (DEPTH),
        .RESET_PC   (32'd0),
        .HALT_OPCODE(8'h0F)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .MemAddr      (mem_addr),
        .MemInst      (mem_inst),
        .RedirectValid(redir),
        .RedirectPC   (redir_pc),
        .InstValid    (inst_valid),
        .InstReady    (ready),
        .InstOut      (inst_out),
        .InstPC       (inst_pc),
        .Halted       (halted)
    );

    always @(posedge clk) mem_inst <= mem[mem_addr[9:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched word addresses in fetch order; an entry
    // is "arrived" once its memory data has returned and it can be presented.
    typedef struct {
        int pc;
        bit arrived;
    } ent_t;

    ent_t        q[$];
    int          m_pc;
    bit          m_stop;
    bit          m_halted;
    bit          m_live = 1'b0;
    logic [31:0] m_out;
    logic [31:0] m_opc;
    bit          m_vis;
    bit          m_pop;
    bit          m_hcap;
    bit          m_issue;
    int          m_occ;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_pc     = 0;
            m_stop   = 1'b0;
            m_halted = 1'b0;
            m_out    = 32'd0;
            m_opc    = 32'd0;
            m_live   = 1'b1;
        end else if (m_live) begin
            m_vis  = (q.size() > 0) && q[0].arrived;
            m_pop  = m_vis && ready;
            m_hcap = (q.size() > 0) && !q[q.size()-1].arrived
                     && (mem[q[q.size()-1].pc][31:24] == 8'h0F);
            m_occ  = q.size();
            if (m_pop) begin
                if (mem[q[0].pc][31:24] == 8'h0F) m_halted = 1'b1;
                void'(q.pop_front());
            end
            if (redir) begin
                q.delete();
                m_pc     = int'(redir_pc % 32'(DEPTH));
                m_stop   = 1'b0;
                m_halted = 1'b0;
            end else begin
                foreach (q[i]) q[i].arrived = 1'b1;
                m_issue = !m_stop && !m_hcap && ((m_occ - int'(m_pop)) < 2);
                if (m_hcap) m_stop = 1'b1;
                if (m_issue) begin
                    q.push_back('{pc: m_pc, arrived: 1'b0});
                    m_pc = (m_pc + 1) % DEPTH;
                end
            end
            if ((q.size() > 0) && q[0].arrived) begin
                m_out = mem[q[0].pc];
                m_opc = 32'(q[0].pc);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid", 32'(inst_valid), 32'((q.size() > 0) && q[0].arrived));
            chk("model_inst", inst_out, m_out);
            chk("model_pc", inst_pc, m_opc);
            chk("model_addr", mem_addr, 32'(m_pc));
            chk("model_halted", 32'(halted), 32'(m_halted));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        mem[0] = 32'h02000000; mem[1] = 32'h02010001; mem[2] = 32'h0402000A;
        mem[3] = 32'h0A080005; mem[4] = 32'h01030000; mem[5] = 32'h0A0A0003;
        mem[6] = 32'h0A0B0004; mem[7] = 32'h08020001; mem[8] = 32'h0A0C0003;
        mem[9] = 32'h0F000000;

        rst = 1'b1; ready = 1'b0; redir = 1'b0; redir_pc = 32'd0;
        step(3);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_out", inst_out, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // First word appears after the second edge; then one per cycle.
        rst = 1'b0; ready = 1'b1;
        step(1); chk("lat_edge1_valid", 32'(inst_valid), 32'd0);
        step(1); chk("lat_edge2_valid", 32'(inst_valid), 32'd1);
        chk("s0_pc", inst_pc, 32'd0); chk("s0_out", inst_out, 32'h02000000);
        step(1); chk("s1_pc", inst_pc, 32'd1); chk("s1_out", inst_out, 32'h02010001);
        step(1); chk("s2_pc", inst_pc, 32'd2); chk("s2_out", inst_out, 32'h0402000A);

        // Stall right after the first valid word.
        rst = 1'b1; step(1); rst = 1'b0; ready = 1'b1;
        step(2); chk("st_first_pc", inst_pc, 32'd0);
        ready = 1'b0;
        repeat (5) begin
            step(1);
            chk("st_out", inst_out, 32'h02000000);
            chk("st_pc", inst_pc, 32'd0);
            chk("st_addr", mem_addr, 32'd2);
        end
        ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("rel_pc", inst_pc, 32'(k));
        end
        chk("rel_out5", inst_out, 32'h0A0A0003);

        // Redirect to 3 while PC 5 is presented.
        redir = 1'b1; redir_pc = 32'd3;
        step(1); redir = 1'b0;
        chk("rd_e1_valid", 32'(inst_valid), 32'd0);
        step(1); chk("rd_e2_valid", 32'(inst_valid), 32'd0);
        step(1); chk("rd_pc", inst_pc, 32'd3); chk("rd_out", inst_out, 32'h0A080005);
        step(1); chk("rd_next_pc", inst_pc, 32'd4);

        // Run into HALT at PC 9.
        n = 0;
        while (!(inst_valid && inst_pc == 32'd9) && n < 20) begin
            step(1);
            n++;
        end
        chk("halt_pc", inst_pc, 32'd9);
        chk("halt_out", inst_out, 32'h0F000000);
        step(1);
        chk("halted_set", 32'(halted), 32'd1);
        chk("halted_valid", 32'(inst_valid), 32'd0);
        chk("halted_addr", mem_addr, 32'd10);
        step(3);
        chk("halted_hold", 32'(halted), 32'd1);
        chk("halted_valid_hold", 32'(inst_valid), 32'd0);
        chk("halted_addr_hold", mem_addr, 32'd10);
        redir = 1'b1; redir_pc = 32'd0;
        step(1); redir = 1'b0;
        chk("halt_clear", 32'(halted), 32'd0);
        step(2); chk("refetch_pc", inst_pc, 32'd0); chk("refetch_out", inst_out, 32'h02000000);

        // Address wrap.
        redir = 1'b1; redir_pc = 32'd1023;
        step(1); redir = 1'b0;
        step(2); chk("wrap_pc_1023", inst_pc, 32'd1023);
        step(1); chk("wrap_pc_0", inst_pc, 32'd0);
        redir = 1'b1; redir_pc = 32'd1027;
        step(1); redir = 1'b0;
        step(2); chk("mod_pc_3", inst_pc, 32'd3);

        // Reset with the buffer full.
        ready = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_out", inst_out, 32'd0);
        chk("mid_rst_pc", inst_pc, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        rst = 1'b0; ready = 1'b1;
        step(2); chk("post_rst_pc", inst_pc, 32'd0); chk("post_rst_out", inst_out, 32'h02000000);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
